// File: rtl/mmx_wb_pkg.sv
// mmx_wb_pkg: shared types for the alu3 writeback buffer.
// Entry layout and fixed MMX/ECX widths.
package mmx_wb_pkg;

    localparam int MMX_IDX_W = 3;
    localparam int ECX_W     = 32;

    typedef struct packed {
        logic [63:0]          data;
        logic [MMX_IDX_W-1:0] mm_idx;
        logic                 wr_mm;
        logic                 wr_ecx;
    } wb_entry_t;

endpackage

// File: rtl/mmx_wb_fifo.sv
// mmx_wb_fifo: DEPTH-entry in-order ring of wb_entry_t.
// Flush beats push/pop; pointers wrap, count tells full from empty.
module mmx_wb_fifo
    import mmx_wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  wb_entry_t             wdata,
    output wb_entry_t             head,
    output logic                  head_valid,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic [PTR_W-1:0]      head_ptr,
    output wb_entry_t [DEPTH-1:0] ents,
    output logic [DEPTH-1:0]      valids
);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  do_push;
    logic                  do_pop;

    assign full       = (cnt_q == CNT_W'(DEPTH));
    assign head_valid = vld_q[head_q];
    assign head       = mem_q[head_q];
    assign count      = cnt_q;
    assign head_ptr   = head_q;
    assign ents       = mem_q;
    assign valids     = vld_q;

    // No pass-through: a full ring refuses even if it pops this cycle
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && head_valid && !flush;

    // Next-state for ring contents, pointers and occupancy
    always_comb begin
        mem_d  = mem_q;
        vld_d  = vld_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush) begin
            vld_d  = '0;
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_pop) begin
                vld_d[head_q] = 1'b0;
                head_d        = head_q + PTR_W'(1);
            end
            if (do_push) begin
                mem_d[tail_q] = wdata;
                vld_d[tail_q] = 1'b1;
                tail_d        = tail_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q  <= '0;
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            vld_q  <= vld_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/mmx_wb_buffer.sv
// mmx_wb_buffer: alu3 execute-to-writeback queue driving MMX and ECX ports.
// Define MMX_WB_FWD_EN to forward pending MMX results to execute.
module mmx_wb_buffer
    import mmx_wb_pkg::*;
#(
    parameter  int DEPTH  = 2,
    parameter  int DATA_W = 64,
    parameter  int IDX_W  = 3,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] alu_res3,
    input  logic [IDX_W-1:0]  ex_mm_idx,
    input  logic              ex_wr_mm,
    input  logic              ex_wr_ecx,
    input  logic              flush,
    input  logic              wb_stall,
    output logic              mm_wr_en,
    output logic [IDX_W-1:0]  mm_wr_idx,
    output logic [DATA_W-1:0] mm_wr_data,
    output logic              ecx_wr_en,
    output logic [ECX_W-1:0]  ecx_wr_data,
    output logic [CNT_W-1:0]  count,
    input  logic [IDX_W-1:0]  fwd_rd_idx,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    wb_entry_t             wdata;
    wb_entry_t             head;
    logic                  head_valid;
    logic                  full;
    logic [PTR_W-1:0]      head_ptr;
    wb_entry_t [DEPTH-1:0] ents;
    logic [DEPTH-1:0]      valids;

    assign wdata.data   = 64'(alu_res3);
    assign wdata.mm_idx = MMX_IDX_W'(ex_mm_idx);
    assign wdata.wr_mm  = ex_wr_mm;
    assign wdata.wr_ecx = ex_wr_ecx;
    assign ex_ready     = !full;

    mmx_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ex_valid),
        .pop       (!wb_stall),
        .flush     (flush),
        .wdata     (wdata),
        .head      (head),
        .head_valid(head_valid),
        .count     (count),
        .full      (full),
        .head_ptr  (head_ptr),
        .ents      (ents),
        .valids    (valids)
    );

    // Head decode: strobes on retire, payload zeroed when empty
    always_comb begin
        mm_wr_en    = 1'b0;
        ecx_wr_en   = 1'b0;
        mm_wr_idx   = '0;
        mm_wr_data  = '0;
        ecx_wr_data = '0;
        if (head_valid) begin
            mm_wr_en    = !wb_stall && head.wr_mm;
            ecx_wr_en   = !wb_stall && head.wr_ecx;
            mm_wr_idx   = IDX_W'(head.mm_idx);
            mm_wr_data  = DATA_W'(head.data);
            ecx_wr_data = head.data[ECX_W-1:0];
        end
    end

`ifdef MMX_WB_FWD_EN
    logic [PTR_W-1:0] fwd_p;

    // Scan oldest to youngest so the entry nearest the tail wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_p    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_p = head_ptr + PTR_W'(k);
            if (valids[fwd_p] && ents[fwd_p].wr_mm &&
                ents[fwd_p].mm_idx == MMX_IDX_W'(fwd_rd_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = DATA_W'(ents[fwd_p].data);
            end
        end
    end
`else
    logic unused_fwd;

    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
    assign unused_fwd = ^{fwd_rd_idx, ents, valids, head_ptr};
`endif

endmodule
